// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shifter: operation select and FSM states.
// Pure type/constant package; no logic, no latency, no flow control.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROL = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift of din by k bits (k never exceeds the caller's per-cycle step).
// Zero latency, no flow control; SRA fills from din's MSB, ROL wraps MSB bits into the LSB.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int KW    = 1
) (
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = din;
    case (mode_e'(mode))
      MODE_SLL: dout = din << k;
      MODE_SRL: dout = din >> k;
      MODE_SRA: dout = $signed(din) >>> k;
      // A right shift by WIDTH yields zero, so k == 0 leaves din untouched.
      MODE_ROL: dout = (din << k) | (din >> (WIDTH - int'(k)));
      default:  dout = din;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: moves y by up to STEP bits per cycle until shamt is consumed.
// done pulses ceil(shamt/STEP)+1 cycles after acceptance; start is only honoured in IDLE.
module seq_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   y
);

  // rem never exceeds 2**SHAMT_W-1, so clamping STEP there leaves min(STEP, rem) unchanged
  // while keeping all remaining-count arithmetic at SHAMT_W bits.
  localparam int REM_MAX    = (1 << SHAMT_W) - 1;
  localparam int STEP_SAT_I = (STEP > REM_MAX) ? REM_MAX : STEP;
  localparam logic [SHAMT_W-1:0] STEP_SAT = STEP_SAT_I[SHAMT_W-1:0];

  state_e             state;
  state_e             state_nxt;
  mode_e              op;
  logic [SHAMT_W-1:0] rem;
  logic [SHAMT_W-1:0] k_amt;
  logic [SHAMT_W-1:0] rem_nxt;
  logic [WIDTH-1:0]   y_step;

  assign k_amt   = (rem < STEP_SAT) ? rem : STEP_SAT;
  assign rem_nxt = rem - k_amt;

  shift_step #(
    .WIDTH (WIDTH),
    .KW    (SHAMT_W)
  ) u_step (
    .mode (op),
    .din  (y),
    .k    (k_amt),
    .dout (y_step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      op    <= MODE_SLL;
      rem   <= '0;
      y     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            y   <= a;
            op  <= mode_e'(mode);
            rem <= shamt;
          end
        end
        ST_SHIFT: begin
          y   <= y_step;
          rem <= rem_nxt;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (shamt != '0) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (rem_nxt == '0) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: STEP=1 and STEP=4 instances share stimulus; a cycle-count model
// plus literal expectations check busy, done timing and the final y.
module tb_seq_shifter;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode  = 2'b00;
  logic [31:0] a     = '0;
  logic [4:0]  shamt = '0;

  logic        busy1, done1, busy4, done4;
  logic [31:0] y1, y4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(32), .STEP(1), .SHAMT_W(5)) u_s1 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .a(a), .shamt(shamt),
    .busy(busy1), .done(done1), .y(y1)
  );

  seq_shifter #(.WIDTH(32), .STEP(4), .SHAMT_W(5)) u_s4 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .a(a), .shamt(shamt),
    .busy(busy4), .done(done4), .y(y4)
  );

  function automatic logic [31:0] ref_shift(input logic [31:0] v, input logic [1:0] m, input int s);
    logic [31:0] r;
    case (m)
      2'b00:   r = v << s;
      2'b01:   r = v >> s;
      2'b10:   r = $signed(v) >>> s;
      default: r = (s == 0) ? v : ((v << s) | (v >> (32 - s)));
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: per instance, cycles elapsed since acceptance and the cycle done is due.
  bit          m_act[2]  = '{0, 0};
  bit          m_yk[2]   = '{0, 0};
  int          m_cyc[2];
  int          m_done_at[2];
  logic [31:0] m_res[2];
  logic [31:0] m_y[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_act[i] = 0;
        m_yk[i]  = 1;
        m_y[i]   = '0;
      end else if (!m_act[i]) begin
        if (start) begin
          m_act[i]     = 1;
          m_cyc[i]     = 1;
          m_res[i]     = ref_shift(a, mode, int'(shamt));
          m_done_at[i] = (i == 0) ? int'(shamt) + 1 : (int'(shamt) + 3) / 4 + 1;
          m_yk[i]      = 0;
        end
      end else if (m_cyc[i] == m_done_at[i]) begin
        m_act[i] = 0;
      end else begin
        m_cyc[i]++;
      end
      if (m_act[i] && m_cyc[i] == m_done_at[i]) begin
        m_yk[i] = 1;
        m_y[i]  = m_res[i];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("cyc busy step%0d", (i == 0) ? 1 : 4), (i == 0) ? busy1 : busy4,
            m_act[i] && (m_cyc[i] < m_done_at[i]));
      check($sformatf("cyc done step%0d", (i == 0) ? 1 : 4), (i == 0) ? done1 : done4,
            m_act[i] && (m_cyc[i] == m_done_at[i]));
      if (m_yk[i])
        check($sformatf("cyc y step%0d", (i == 0) ? 1 : 4), (i == 0) ? y1 : y4, m_y[i]);
    end
  end

  // Called at a negedge in an idle cycle; returns at the negedge of an idle cycle.
  task automatic run_op(input string name, input logic [31:0] av, input logic [1:0] m,
                        input int sh, input logic [31:0] ey, input int ed1, input int ed4,
                        input int glitch);
    int d1 = -1;
    int d4 = -1;
    int b1 = 0;
    int b4 = 0;
    start = 1'b1; a = av; mode = m; shamt = 5'(sh);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == glitch);
      a     = (c == glitch) ? 32'hFFFF_FFFF : $urandom;
      mode  = 2'($urandom);
      shamt = 5'($urandom);
      if (busy1) b1++;
      if (busy4) b4++;
      if (done1 && d1 < 0) begin d1 = c; check({name, " y step1"}, y1, ey); end
      if (done4 && d4 < 0) begin d4 = c; check({name, " y step4"}, y4, ey); end
      if (d1 >= 0 && d4 >= 0) break;
    end
    check({name, " done cycle step1"}, d1, ed1);
    check({name, " done cycle step4"}, d4, ed4);
    check({name, " busy cycles step1"}, b1, ed1 - 1);
    check({name, " busy cycles step4"}, b4, ed4 - 1);
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset y step1", y1, 32'h0);
    check("reset y step4", y4, 32'h0);
    check("reset busy step1", busy1, 1'b0);
    check("reset done step4", done4, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    run_op("sll2",   32'h1234_5678, 2'b00, 2,  32'h48D1_59E0, 3,  2, 0);
    run_op("sra4",   32'hFEDC_BA98, 2'b10, 4,  32'hFFED_CBA9, 5,  2, 0);
    run_op("srl4",   32'hFEDC_BA98, 2'b01, 4,  32'h0FED_CBA9, 5,  2, 0);
    run_op("rol1",   32'h8000_0001, 2'b11, 1,  32'h0000_0003, 2,  2, 0);
    run_op("sll0",   32'hDEAD_BEEF, 2'b00, 0,  32'hDEAD_BEEF, 1,  1, 0);
    run_op("sll31",  32'h0000_0001, 2'b00, 31, 32'h8000_0000, 32, 9, 0);
    run_op("ignore", 32'h0000_0001, 2'b00, 5,  32'h0000_0020, 6,  3, 2);
    run_op("sra31",  32'h8000_0000, 2'b10, 31, 32'hFFFF_FFFF, 32, 9, 0);
    run_op("srl31",  32'h8000_0000, 2'b01, 31, 32'h0000_0001, 32, 9, 0);
    run_op("rol8",   32'h1234_5678, 2'b11, 8,  32'h3456_7812, 9,  3, 0);
    run_op("rol31",  32'h0000_0003, 2'b11, 31, 32'h8000_0001, 32, 9, 0);
    run_op("srapos", 32'h7000_0000, 2'b10, 5,  32'h0380_0000, 6,  3, 0);

    // Abort an SRA by 10 with reset held through cycle 2.
    start = 1'b1; a = 32'h8000_0000; mode = 2'b10; shamt = 5'd10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort y step1", y1, 32'h0);
    check("abort y step4", y4, 32'h0);
    check("abort busy step1", busy1, 1'b0);
    check("abort busy step4", busy4, 1'b0);
    check("abort done step1", done1, 1'b0);
    run_op("after_rst", 32'hF0F0_0000, 2'b10, 3, 32'hFE1E_0000, 4, 2, 0);

    for (int n = 0; n < 8; n++) begin
      logic [31:0] av;
      logic [1:0]  m;
      int          sh;
      av = $urandom;
      m  = 2'($urandom);
      sh = $urandom_range(0, 31);
      run_op($sformatf("rand%0d", n), av, m, sh, ref_shift(av, m, sh), sh + 1, (sh + 3) / 4 + 1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
